// File: rtl/gl_cmd_fetch.sv
// Command-stream reader: walks a word-addressed command buffer, decodes headers and
// issues commands plus operand beats downstream. Optional macro: GL_CMD_FETCH_SKIP_UNKNOWN_EN.
module gl_cmd_fetch #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] hdr_addr,
  input  logic [31:0]       hdr_data,
  output logic [ADDR_W-1:0] op_addr,
  input  logic [31:0]       op_data0,
  input  logic [31:0]       op_data1,
  input  logic [31:0]       op_data2,
  input  logic [31:0]       op_data3,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [7:0]        cmd_opcode,
  output logic [7:0]        cmd_arg,
  output logic              data_valid,
  input  logic              data_ready,
  output logic [127:0]      data_word,
  output logic [2:0]        data_count,
  output logic              data_last
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    CMD  = 3'd2,
    DATA = 3'd3,
    SKIP = 3'd4,
    HALT = 3'd5
  } state_e;

  localparam logic [7:0] OP_MATRIX_MODE = 8'h10;
  localparam logic [7:0] OP_LOAD_MATRIX = 8'h13;
  localparam logic [7:0] OP_VERTEX      = 8'h03;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic [7:0]        opcode_q, opcode_d;
  logic [7:0]        arg_q, arg_d;
  logic [4:0]        rem_q, rem_d;

  logic              hdr_known;
  logic [4:0]        hdr_count;
  logic              at_end;
  logic [ADDR_W-1:0] room;
  logic [ADDR_W-3:0] room_words;
  logic [2:0]        want;
  logic              short_beat;
  logic [2:0]        beat_count;
  logic              no_beat;
  logic [4:0]        rem_after;
  logic              unused_bits;

  assign unused_bits = ^{hdr_data[31:12], room[1:0]};

  // Header decode: operand word count per known opcode.
  always_comb begin
    hdr_known = 1'b1;
    hdr_count = 5'd0;
    case (hdr_data[7:0])
      OP_MATRIX_MODE: hdr_count = 5'd0;
      OP_LOAD_MATRIX: hdr_count = 5'd16;
      OP_VERTEX:      hdr_count = 5'd3;
      default:        hdr_known = 1'b0;
    endcase
  end

  // Beat sizing; a beat that would run past end is clamped to the whole words left.
  always_comb begin
    at_end     = (ptr_q >= end_q);
    room       = end_q - ptr_q;
    room_words = room[ADDR_W-1:2];
    want       = (rem_q > 5'd4) ? 3'd4 : rem_q[2:0];
    short_beat = !at_end && (room_words < (ADDR_W-2)'(want));
    beat_count = short_beat ? room_words[2:0] : want;
    no_beat    = at_end || (beat_count == 3'd0);
    rem_after  = rem_q - {2'b00, beat_count};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      end_q    <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      opcode_q <= 8'h00;
      arg_q    <= 8'h00;
      rem_q    <= 5'd0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      end_q    <= end_d;
      err_q    <= err_d;
      done_q   <= done_d;
      opcode_q <= opcode_d;
      arg_q    <= arg_d;
      rem_q    <= rem_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    end_d    = end_q;
    err_d    = err_q;
    done_d   = 1'b0;
    opcode_d = opcode_q;
    arg_d    = arg_q;
    rem_d    = rem_q;
    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          ptr_d   = base_addr;
          end_d   = end_addr;
          err_d   = 1'b0;
          state_d = HDR;
        end
      end
      HDR: begin
        if (at_end) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (hdr_known) begin
          opcode_d = hdr_data[7:0];
          arg_d    = {4'h0, hdr_data[11:8]};
          rem_d    = hdr_count;
          state_d  = CMD;
        end else begin
          err_d = 1'b1;
`ifdef GL_CMD_FETCH_SKIP_UNKNOWN_EN
          state_d = SKIP;
`else
          state_d = HALT;
`endif
        end
      end
      CMD: begin
        if (cmd_ready) begin
          ptr_d   = ptr_q + ADDR_W'(4);
          state_d = (rem_q != 5'd0) ? DATA : HDR;
        end
      end
      DATA: begin
        // Operands missing entirely: the stream ends without a beat.
        if (no_beat) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (data_ready) begin
          ptr_d = ptr_q + ADDR_W'({beat_count, 2'b00});
          rem_d = rem_after;
          if (short_beat) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (rem_after == 5'd0) begin
            state_d = HDR;
          end
        end
      end
      SKIP: begin
        ptr_d   = ptr_q + ADDR_W'(4);
        state_d = HDR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != IDLE);
    done       = done_q;
    err        = err_q;
    hdr_addr   = ptr_q;
    op_addr    = ptr_q;
    cmd_valid  = (state_q == CMD);
    cmd_opcode = opcode_q;
    cmd_arg    = arg_q;
    data_valid = (state_q == DATA) && !no_beat;
    data_count = data_valid ? beat_count : 3'd0;
    data_last  = data_valid && (short_beat || (rem_q <= 5'd4));
    data_word  = {(data_count > 3'd3) ? op_data3 : 32'h0,
                  (data_count > 3'd2) ? op_data2 : 32'h0,
                  (data_count > 3'd1) ? op_data1 : 32'h0,
                  (data_count > 3'd0) ? op_data0 : 32'h0};
  end

endmodule
